// File: rtl/nic_pe_driver.sv
// PE-side initiator for the NIC CPU register interface.
// Adds a 4-deep TX FIFO, an RX valid/ready holding register and TX/RX polling with a fairness turn bit.
module nic_pe_driver #(
    parameter int PACKET_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [1:0]              addr,
    output logic [PACKET_WIDTH-1:0] d_in,
    input  logic [PACKET_WIDTH-1:0] d_out,
    output logic                    nicEn,
    output logic                    nicEnWR,
    input  logic                    tx_valid,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    output logic                    tx_ready,
    output logic                    rx_valid,
    output logic [PACKET_WIDTH-1:0] rx_data,
    input  logic                    rx_ready,
    output logic [15:0]             sent_count,
    output logic [15:0]             recv_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OS_REQ,
        S_OS_CHK,
        S_OB_WR,
        S_IS_REQ,
        S_IS_CHK,
        S_IB_REQ,
        S_IB_CHK
    } state_t;

    localparam logic TURN_TX = 1'b0;
    localparam logic TURN_RX = 1'b1;

    state_t                  r_state;
    logic                    r_turn;
    logic                    r_rx_valid;
    logic [PACKET_WIDTH-1:0] r_rx_data;
    logic [15:0]             r_sent_count;
    logic [15:0]             r_recv_count;

    logic [PACKET_WIDTH-1:0] r_fifo [0:3];
    logic [1:0]              r_wr_ptr;
    logic [1:0]              r_rd_ptr;
    logic [2:0]              r_count;

    logic                    w_tx_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_nonempty;
    logic                    w_nic_en;
    logic                    w_nic_wr;
    logic [1:0]              w_addr;
    logic [PACKET_WIDTH-1:0] w_d_in;

    assign w_tx_ready      = (r_count != 3'd4);
    assign w_push          = tx_valid & w_tx_ready;
    assign w_pop           = (r_state == S_OB_WR);
    assign w_fifo_nonempty = (r_count != 3'd0);

    // NIC strobes decode from the state register only, so a reset clears them at once
    always_comb begin
        w_nic_en = 1'b0;
        w_nic_wr = 1'b0;
        w_addr   = 2'b00;
        w_d_in   = '0;
        case (r_state)
            S_OS_REQ: begin
                w_nic_en = 1'b1;
                w_addr   = 2'b11;
            end
            S_OB_WR: begin
                w_nic_en = 1'b1;
                w_nic_wr = 1'b1;
                w_addr   = 2'b10;
                w_d_in   = r_fifo[r_rd_ptr];
            end
            S_IS_REQ: begin
                w_nic_en = 1'b1;
                w_addr   = 2'b01;
            end
            S_IB_REQ: begin
                w_nic_en = 1'b1;
                w_addr   = 2'b00;
            end
            default: begin
                w_nic_en = 1'b0;
            end
        endcase
    end

    // TX FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= tx_data;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Polling FSM with fairness turn, RX holding register and packet counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_turn       <= TURN_TX;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_sent_count <= 16'd0;
            r_recv_count <= 16'd0;
        end else begin
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if ((r_turn == TURN_TX) && w_fifo_nonempty) begin
                        r_state <= S_OS_REQ;
                    end else if (!r_rx_valid) begin
                        r_state <= S_IS_REQ;
                    end else if (w_fifo_nonempty) begin
                        r_state <= S_OS_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OS_REQ: r_state <= S_OS_CHK;
                S_OS_CHK: begin
                    if (!d_out[0]) begin
                        r_state <= S_OB_WR;
                    end else begin
                        r_state <= S_IDLE;
                        r_turn  <= TURN_RX;
                    end
                end
                S_OB_WR: begin
                    r_sent_count <= r_sent_count + 16'd1;
                    r_state      <= S_IDLE;
                    r_turn       <= TURN_RX;
                end
                S_IS_REQ: r_state <= S_IS_CHK;
                S_IS_CHK: begin
                    if (d_out[0]) begin
                        r_state <= S_IB_REQ;
                    end else begin
                        r_state <= S_IDLE;
                        r_turn  <= TURN_TX;
                    end
                end
                S_IB_REQ: r_state <= S_IB_CHK;
                S_IB_CHK: begin
                    // Never reached with rx_valid set, so the held packet is safe
                    r_rx_data    <= d_out;
                    r_rx_valid   <= 1'b1;
                    r_recv_count <= r_recv_count + 16'd1;
                    r_state      <= S_IDLE;
                    r_turn       <= TURN_TX;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_turn  <= TURN_TX;
                end
            endcase
        end
    end

    assign addr       = w_addr;
    assign d_in       = w_d_in;
    assign nicEn      = w_nic_en;
    assign nicEnWR    = w_nic_wr;
    assign tx_ready   = w_tx_ready;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign sent_count = r_sent_count;
    assign recv_count = r_recv_count;

endmodule

// File: tb/tb_nic_pe_driver.sv
// Self-checking bench for nic_pe_driver: a behavioural NIC register model plus packet-order scoreboards.
module tb_nic_pe_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWR;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic        rx_ready;
    logic [15:0] sent_count;
    logic [15:0] recv_count;

    nic_pe_driver #(.PACKET_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWR(nicEnWR), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .sent_count(sent_count), .recv_count(recv_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // NIC model state and scoreboards
    bit          in_full, out_full;
    logic [63:0] in_buf;
    bit          drain_en, feed_en, fair_mode;
    int          drain_pct, feed_pct;
    logic [63:0] tx_exp[$];
    logic [63:0] rx_exp[$];
    int          occ;
    logic [15:0] exp_sent, exp_recv;
    int          n_wr, n_rd0, n_rd1, n_rd3;
    int          last_kind;
    bit          push_ok, wr_now;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic note_kind(input int kind);
        if (fair_mode) begin
            if (last_kind != 0) check("fair_alternate", 64'(kind), 64'((last_kind == 1) ? 2 : 1));
            last_kind = kind;
        end
    endtask

    // One clock: commit handshakes for the coming edge, then model the NIC at the next negedge
    task automatic cycle();
        push_ok = 1'b0;
        if (tx_valid && tx_ready) begin
            tx_exp.push_back(tx_data);
            occ++;
            push_ok = 1'b1;
        end
        if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) check("rx_unexpected", 64'd1, 64'd0);
            else check("rx_data_order", rx_data, rx_exp.pop_front());
        end
        @(negedge clk);
        wr_now = 1'b0;
        if (!reset) begin
            check("tx_ready_occ", {63'd0, tx_ready}, 64'(occ != 4));
            if (nicEn && nicEnWR) begin
                wr_now = 1'b1;
                n_wr++;
                check("wr_addr", {62'd0, addr}, 64'd2);
                check("wr_when_full", {63'd0, out_full}, 64'd0);
                if (tx_exp.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
                else check("wr_data_order", d_in, tx_exp.pop_front());
                occ--;
                out_full = 1'b1;
                exp_sent = exp_sent + 16'd1;
                note_kind(1);
            end else if (nicEn) begin
                case (addr)
                    2'b00: begin
                        check("rd_buf_when_empty", {63'd0, in_full}, 64'd1);
                        d_out = in_buf;
                        in_full = 1'b0;
                        n_rd0++;
                        exp_recv = exp_recv + 16'd1;
                        note_kind(2);
                    end
                    2'b01: begin
                        check("is_poll_while_rx_valid", {63'd0, rx_valid}, 64'd0);
                        d_out = {63'd0, in_full};
                        n_rd1++;
                    end
                    2'b11: begin
                        d_out = {63'd0, out_full};
                        n_rd3++;
                    end
                    default: d_out = 64'd0;
                endcase
            end else begin
                check("idle_bus", {d_in, 1'b0, nicEnWR, addr} == 68'd0 ? 64'd0 : 64'd1, 64'd0);
            end
            if (drain_en && out_full && !wr_now && ($urandom_range(99) < drain_pct)) out_full = 1'b0;
            if (feed_en && !in_full && ($urandom_range(99) < feed_pct)) begin
                in_buf = {$urandom, $urandom};
                in_full = 1'b1;
                rx_exp.push_back(in_buf);
            end
        end
    endtask

    task automatic quiesce(input string tag);
        bit done = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        feed_en = 1'b0;
        drain_en = 1'b1;
        drain_pct = 100;
        for (int i = 0; i < 400 && !done; i++) begin
            cycle();
            done = (tx_exp.size() == 0) && (rx_exp.size() == 0) && !rx_valid;
        end
        check(tag, {63'd0, done}, 64'd1);
        cycle();
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus"}, {d_in[61:0], nicEn, nicEnWR} == 64'd0 && addr == 2'b00 && d_in[63:62] == 2'b00 ? 64'd0 : 64'd1, 64'd0);
        check({tag, "_rx_valid"}, {63'd0, rx_valid}, 64'd0);
        check({tag, "_rx_data"}, rx_data, 64'd0);
        check({tag, "_sent"}, {48'd0, sent_count}, 64'd0);
        check({tag, "_recv"}, {48'd0, recv_count}, 64'd0);
        check({tag, "_tx_ready"}, {63'd0, tx_ready}, 64'd1);
    endtask

    initial begin
        int acc, n1, n3, nw, w0;
        bit found;
        reset = 1'b1; tx_valid = 1'b0; tx_data = 64'd0; rx_ready = 1'b0; d_out = 64'd0;
        in_full = 1'b0; out_full = 1'b0; in_buf = 64'd0; drain_en = 1'b0; feed_en = 1'b0;
        fair_mode = 1'b0; drain_pct = 0; feed_pct = 0; occ = 0; exp_sent = 16'd0; exp_recv = 16'd0;
        n_wr = 0; n_rd0 = 0; n_rd1 = 0; n_rd3 = 0; last_kind = 0;
        #1;
        check_reset_outputs("por");

        // RX latency: input full with 0x1234, reset released at a negedge (cycle 0 = IDLE)
        in_full = 1'b1; in_buf = 64'h1234; rx_exp.push_back(64'h1234);
        @(negedge clk);
        reset = 1'b0;
        cycle(); check("rx_lat_c1_is_req", {60'd0, nicEn, nicEnWR, addr}, 64'b1001);
        cycle(); check("rx_lat_c2", {63'd0, nicEn}, 64'd0);
        cycle(); check("rx_lat_c3_ib_req", {60'd0, nicEn, nicEnWR, addr}, 64'b1000);
        cycle(); check("rx_lat_c4_not_valid", {63'd0, rx_valid}, 64'd0);
        cycle(); check("rx_lat_c5_valid", {63'd0, rx_valid}, 64'd1);
        check("rx_lat_c5_data", rx_data, 64'h1234);

        // Held packet: no further status polls while rx_ready stays low
        n1 = n_rd1;
        repeat (20) cycle();
        check("rx_hold_valid", {63'd0, rx_valid}, 64'd1);
        check("rx_hold_data", rx_data, 64'h1234);
        check("rx_hold_no_poll", 64'(n_rd1 - n1), 64'd0);

        // TX latency with the FSM parked in IDLE (rx held, FIFO empty)
        tx_valid = 1'b1; tx_data = 64'hDEAD_BEEF_0000_0001;
        cycle(); tx_valid = 1'b0;
        check("tx_lat_c1", {60'd0, nicEn, nicEnWR, addr}, 64'b0000);
        cycle(); check("tx_lat_c2_os_req", {60'd0, nicEn, nicEnWR, addr}, 64'b1011);
        cycle(); check("tx_lat_c3", {60'd0, nicEn, nicEnWR, addr}, 64'b0000);
        cycle(); check("tx_lat_c4_ob_wr", {60'd0, nicEn, nicEnWR, addr}, 64'b1110);
        check("tx_lat_c4_d_in", d_in, 64'hDEAD_BEEF_0000_0001);
        cycle(); check("tx_sent_1", {48'd0, sent_count}, 64'd1);

        // Release the held packet
        rx_ready = 1'b1; cycle(); rx_ready = 1'b0;
        check("rx_release_valid", {63'd0, rx_valid}, 64'd0);
        check("rx_recv_1", {48'd0, recv_count}, 64'd1);

        // Backpressure: output stays full (set by the previous write)
        n3 = n_rd3; nw = n_wr; acc = 0;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1; tx_data = 64'hA0 + 64'(i);
            cycle();
            if (push_ok) acc++;
        end
        tx_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd4);
        check("bp_tx_ready_low", {63'd0, tx_ready}, 64'd0);
        repeat (30) cycle();
        check("bp_no_writes", 64'(n_wr - nw), 64'd0);
        check("bp_os_repeats", 64'((n_rd3 - n3) >= 2), 64'd1);
        quiesce("bp_drain_timeout");
        check("bp_sent_5", {48'd0, sent_count}, 64'd5);

        // Fairness: fill FIFO behind a full output, then open both channels
        out_full = 1'b1; drain_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tx_valid = 1'b1; tx_data = {$urandom, $urandom};
            cycle();
            found = !tx_ready;
        end
        check("fair_fill", {63'd0, found}, 64'd1);
        rx_ready = 1'b1; feed_en = 1'b1; feed_pct = 100; drain_en = 1'b1; drain_pct = 100;
        repeat (12) begin tx_data = {$urandom, $urandom}; cycle(); end
        w0 = n_wr; fair_mode = 1'b1; last_kind = 0;
        repeat (90) begin tx_data = {$urandom, $urandom}; cycle(); end
        fair_mode = 1'b0;
        check("fair_progress", 64'((n_wr - w0) >= 8), 64'd1);
        quiesce("fair_drain_timeout");
        check("fair_sent", {48'd0, sent_count}, {48'd0, exp_sent});
        check("fair_recv", {48'd0, recv_count}, {48'd0, exp_recv});

        // Randomised traffic against the NIC model
        feed_en = 1'b1; drain_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                drain_pct = $urandom_range(90, 10);
                feed_pct = $urandom_range(90, 10);
            end
            tx_valid = ($urandom_range(2) != 0);
            tx_data = {$urandom, $urandom};
            rx_ready = ($urandom_range(1) != 0);
            cycle();
        end
        quiesce("rand_drain_timeout");
        check("rand_sent", {48'd0, sent_count}, {48'd0, exp_sent});
        check("rand_recv", {48'd0, recv_count}, {48'd0, exp_recv});

        // Counter wrap
        force dut.r_sent_count = 16'hFFFF;
        cycle();
        release dut.r_sent_count;
        cycle();
        exp_sent = 16'hFFFF;
        check("wrap_preload", {48'd0, sent_count}, 64'hFFFF);
        tx_valid = 1'b1; tx_data = 64'h5A5A; cycle(); tx_valid = 1'b0;
        quiesce("wrap_timeout");
        check("wrap_zero", {48'd0, sent_count}, 64'd0);
        check("wrap_model", {48'd0, sent_count}, {48'd0, exp_sent});

        // Reset asserted asynchronously in the middle of OB_WR
        drain_en = 1'b1; drain_pct = 100;
        tx_valid = 1'b1; tx_data = 64'h7777; cycle(); tx_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            found = wr_now;
        end
        check("rst_reach_ob_wr", {63'd0, found}, 64'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tx_exp.delete(); rx_exp.delete(); occ = 0; exp_sent = 16'd0; exp_recv = 16'd0;
        in_full = 1'b0; out_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_release");
        cycle();
        check("rst_idle_then_is_req", {60'd0, nicEn, nicEnWR, addr}, 64'b1001);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nic_pe_driver.md
# nic_pe_driver

Processing-element-side initiator for the NIC CPU interface (`addr`/`d_in`/`d_out`/`nicEn`/`nicEnWR`). It is instantiated once per mesh node, for example next to each NIC in a mesh row, and gives a simple PE a streaming packet interface in place of direct register access.

- **Transmit:** buffers outgoing packets in a 4-entry FIFO, polls the NIC output-channel status, and writes a packet into the output buffer whenever that buffer is empty.
- **Receive:** polls the NIC input-channel status, reads the input buffer when it is full, and presents the packet on a valid/ready port.

## Interface
Parameters
- `PACKET_WIDTH`, 64, width of a packet and of all NIC data buses.

Ports
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  out  2  NIC register select.
- `d_in`  out  PACKET_WIDTH  write data to the NIC.
- `d_out`  in  PACKET_WIDTH  read data from the NIC.
- `nicEn`  out  1  NIC access strobe.
- `nicEnWR`  out  1  1 = write access, 0 = read access.
- `tx_valid`  in  1  PE offers a packet.
- `tx_data`  in  PACKET_WIDTH  packet from the PE.
- `tx_ready`  out  1  FIFO can accept a packet (count < 4).
- `rx_valid`  out  1  received packet is held on `rx_data`.
- `rx_data`  out  PACKET_WIDTH  received packet.
- `rx_ready`  in  1  PE consumes the packet.
- `sent_count`  out  16  packets written to the NIC.
- `recv_count`  out  16  packets read from the NIC.

## Operation
- **NIC register map** (addr):
  - 00 input buffer, read; reading it clears input status.
  - 01 input status; `d_out[0]` = 1 means full.
  - 10 output buffer, write.
  - 11 output status; `d_out[0]` = 1 means full.
- **TX FIFO:** depth 4, first-in first-out.
  - A push occurs when `tx_valid & tx_ready`.
  - `tx_ready = (count != 4)`. It is not relaxed for a same-cycle pop.
  - A pop occurs only in OB_WR.
- **Fairness:** a `turn` register (TX/RX) selects which channel IDLE tries first. `turn` flips after every completed poll sequence.
- **FSM states and transitions:**
  - **IDLE:**
    - Go to OS_REQ if `turn`=TX and the FIFO is non-empty.
    - Otherwise go to IS_REQ if `rx_valid`=0.
    - Otherwise go to OS_REQ if the FIFO is non-empty.
    - Otherwise stay in IDLE.
  - **OS_REQ:** read addr 11, then go to OS_CHK.
  - **OS_CHK:** sample `d_out[0]`.
    - If 0, go to OB_WR.
    - If 1, go to IDLE with `turn`=RX.
  - **OB_WR:** write addr 10 with `d_in` = FIFO head; pop the FIFO; increment `sent_count`; go to IDLE with `turn`=RX.
  - **IS_REQ:** read addr 01, then go to IS_CHK.
  - **IS_CHK:** sample `d_out[0]`.
    - If 1, go to IB_REQ.
    - If 0, go to IDLE with `turn`=TX.
  - **IB_REQ:** read addr 00, then go to IB_CHK.
  - **IB_CHK:** capture `rx_data` = `d_out`; set `rx_valid`=1; increment `recv_count`; go to IDLE with `turn`=TX.
- **RX handshake:**
  - `rx_valid` stays high with `rx_data` stable until a cycle in which `rx_ready`=1. It clears on that edge.
  - The receive path is never entered while `rx_valid`=1, so the held packet cannot be overwritten.
- **NIC strobes:** `nicEn`/`nicEnWR`/`addr` are decoded from the registered state only.
  - `nicEn`=1 in OS_REQ, OB_WR, IS_REQ and IB_REQ.
  - `nicEnWR`=1 only in OB_WR.
  - In all other states, `addr`=00 and `d_in`=0.
- **Counters:** 16-bit, wrap from 0xFFFF to 0x0000.
- **Reset** (any time, including mid-sequence):
  - state = IDLE; FIFO flushed (count 0); `turn`=TX.
  - Outputs: `rx_valid`=0, `rx_data`=0, both counters 0, `nicEn`=0, `nicEnWR`=0, `addr`=00, `d_in`=0, `tx_ready`=1.
  - A NIC access interrupted by reset is abandoned, not retried.

## Timing
- At most one NIC access per cycle. Each strobe is a single-cycle pulse.
- NIC read data is registered: `d_out` is sampled in the cycle after the request cycle (the CHK states).
- **TX latency:** packet accepted in cycle 0 (FIFO empty, IDLE, `turn`=TX, NIC output empty):
  - cycle 1 IDLE, cycle 2 OS_REQ, cycle 3 OS_CHK.
  - cycle 4 OB_WR: `nicEn`=`nicEnWR`=1, `addr`=10.
- **RX latency:** IDLE in cycle 0 with NIC input full: IS_REQ in cycle 1, IB_REQ in cycle 3, `rx_valid`=1 from cycle 5.
- **Minimum sequence lengths:** a completed write takes 4 cycles IDLE-to-IDLE; a completed read takes 5.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-OB_WR → all outputs reach their reset values immediately; after release the FSM is in IDLE, `tx_ready`=1 and the counters are 0.
- **Single TX:** push 0xDEAD_BEEF_0000_0001 with the NIC output status at 0 → in cycle 4, `nicEn`=1, `nicEnWR`=1, `addr`=10, `d_in`=0xDEAD_BEEF_0000_0001; `sent_count`=1.
- **FIFO full and backpressure:** NIC output status held at 1; push 5 packets → `tx_ready` drops after the 4th and only 4 are accepted; OS_REQ repeats with no writes. Release the status → packets 1–4 are written in order.
- **RX handshake:** NIC input status=1 with buffer 0x1234, `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0x1234 hold indefinitely with no further addr-01 reads. Pulse `rx_ready` → `rx_valid` clears and `recv_count`=1.
- **Fairness:** both channels continuously ready → writes (addr 10) and reads (addr 00) alternate strictly.
- **Counter wrap:** preload `sent_count` to 0xFFFF by forcing, then do one write → `sent_count`=0x0000.
